// File: rtl/jk_latch.sv
// jk_latch: enable-gated bank of WIDTH independent JK storage cells.
//
// Each bit is a clocked JK cell that updates only on the rising edge of clk.
// A toggle request (j=k=1) therefore flips the bit exactly once per enabled
// edge and cannot oscillate the way a transparent JK latch would.
//
// Ports:
//   clk     rising-edge clock for all state
//   rst     synchronous, active-high reset; clears q and overrides all else
//   j       per-bit set request
//   k       per-bit reset request
//   enable  global update enable; 0 holds every bit
//   q       registered state
//   qn      bitwise complement of q, derived from the q register
module jk_latch #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Per-bit JK next-state; bits never interact.
    always_comb begin
        q_d = q_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   q_d[i] = q_q[i];
                2'b10:   q_d[i] = 1'b1;
                2'b01:   q_d[i] = 1'b0;
                2'b11:   q_d[i] = ~q_q[i];
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    // Reset wins over enable; with enable low every bit holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (enable) begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: tb/tb_jk_latch.sv
// Self-checking bench for jk_latch. Two instances share clock, reset and
// enable: a 4-bit one (vector behaviour) and a 1-bit one driven from bit 0.
// Expected states are pushed to a scoreboard queue as each edge's stimulus is
// driven and popped after that edge.
module tb_jk_latch;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q4;
    logic [3:0] qn4;
    logic [0:0] q1;
    logic [0:0] qn1;

    int checks;
    int failures;

    logic [3:0] model;
    logic       model_valid;
    logic [3:0] sb_q[$];
    string      sb_tag[$];

    jk_latch #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .j      (j),
        .k      (k),
        .enable (enable),
        .q      (q4),
        .qn     (qn4)
    );

    jk_latch #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .j      (j[0:0]),
        .k      (k[0:0]),
        .enable (enable),
        .q      (q1),
        .qn     (qn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs at the falling edge, confirm q has not moved
    // mid-cycle, predict the next state, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [3:0] jv, input logic [3:0] kv);
        logic [3:0] nxt;
        logic [3:0] exp_q;
        string      exp_tag;
        @(negedge clk);
        rst    = r;
        enable = en;
        j      = jv;
        k      = kv;
        #1;
        if (model_valid) begin
            check_eq({tag, "/stable4"}, {28'd0, q4}, {28'd0, model});
            check_eq({tag, "/stable1"}, {31'd0, q1}, {31'd0, model[0]});
        end
        if (r) begin
            nxt = 4'b0000;
        end else if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (jv[b] && kv[b])       nxt[b] = ~model[b];
                else if (jv[b])           nxt[b] = 1'b1;
                else if (kv[b])           nxt[b] = 1'b0;
                else                      nxt[b] = model[b];
            end
        end else begin
            nxt = model;
        end
        sb_q.push_back(nxt);
        sb_tag.push_back(tag);
        model       = nxt;
        model_valid = 1'b1;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            exp_q   = sb_q.pop_front();
            exp_tag = sb_tag.pop_front();
            check_eq({exp_tag, "/q4"}, {28'd0, q4}, {28'd0, exp_q});
            check_eq({exp_tag, "/qn4"}, {28'd0, qn4}, {28'd0, ~exp_q});
            check_eq({exp_tag, "/q1"}, {31'd0, q1}, {31'd0, exp_q[0]});
            check_eq({exp_tag, "/qn1"}, {31'd0, qn1}, {31'd0, ~exp_q[0]});
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model       = 4'b0000;
        model_valid = 1'b0;
        rst         = 1'b1;
        enable      = 1'b0;
        j           = 4'b0000;
        k           = 4'b0000;

        // Reset dominates a pending set.
        step("rst0", 1'b1, 1'b1, 4'hF, 4'h0);
        step("rst1", 1'b1, 1'b1, 4'hF, 4'h0);

        // Mode table.
        step("set",     1'b0, 1'b1, 4'hF, 4'h0);
        step("reset",   1'b0, 1'b1, 4'h0, 4'hF);
        step("hold",    1'b0, 1'b1, 4'h0, 4'h0);
        step("toggle1", 1'b0, 1'b1, 4'hF, 4'hF);
        step("toggle2", 1'b0, 1'b1, 4'hF, 4'hF);

        // Enable gating.
        step("en_set",   1'b0, 1'b1, 4'hF, 4'h0);
        step("dis_rst",  1'b0, 1'b0, 4'h0, 4'hF);
        step("dis_tog",  1'b0, 1'b0, 4'hF, 4'hF);
        step("dis_set",  1'b0, 1'b0, 4'hF, 4'h0);
        step("en_clear", 1'b0, 1'b1, 4'h0, 4'hF);

        // Continuous toggle from 0.
        for (int t = 0; t < 6; t++) begin
            step($sformatf("run%0d", t), 1'b0, 1'b1, 4'hF, 4'hF);
        end

        // Mixed per-bit modes from 0000: 1011 then 1001.
        step("vec0", 1'b0, 1'b1, 4'b1011, 4'b0110);
        step("vec1", 1'b0, 1'b1, 4'b1011, 4'b0110);

        // Reset in the middle of a toggle run.
        step("mt0",   1'b0, 1'b1, 4'hF, 4'hF);
        step("mt1",   1'b0, 1'b1, 4'hF, 4'hF);
        step("mtrst", 1'b1, 1'b1, 4'hF, 4'hF);
        step("mtrel", 1'b0, 1'b1, 4'hF, 4'hF);

        // Random mix.
        for (int t = 0; t < 40; t++) begin
            step($sformatf("rnd%0d", t), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom), 4'($urandom));
        end

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
